i2c_slave: RTL and testbench

- I2C target (responder) for the I2C master side of the APB bridge; answers a single 7-bit address.
- Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its address, receives write bytes and serves read bytes.
- Byte-level handshake to surrounding logic (rx FIFO writer / tx FIFO reader). Open-drain SDA drive; no clock stretching.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_bus_sync.sv | 58 +++++
 rtl/i2c_slave.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths and state encoding for the I2C target
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with registered edge and START/STOP events
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_smp,
  output logic start_det,
  output logic stop_det
);
  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;
  logic scl_rise_d, scl_fall_d, start_d, stop_d;

  always_comb begin
    scl_rise_d = scl_s2_q & ~scl_p_q;
    scl_fall_d = ~scl_s2_q & scl_p_q;
    start_d    = scl_s2_q & scl_p_q & ~sda_s2_q & sda_p_q;
    stop_d     = scl_s2_q & scl_p_q & sda_s2_q & ~sda_p_q;
  end

  // Reset to 1 so releasing reset on an idle bus produces no edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
      scl_p_q    <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_p_q    <= sda_s2_q;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  // sda_p_q is the SDA value that produced the registered events.
  assign sda_smp   = sda_p_q;
endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - single-address I2C target with byte handshake, no clock stretching
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  i2c_reset_n,
  input  logic                  i2c_enable,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rw,
  output logic                  busy
);
  logic scl_rise, scl_fall, sda_smp, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (i2c_reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_smp   (sda_smp),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
  logic [I2C_BYTE_W-1:0] txshreg_q, txshreg_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  tx_req_q, tx_req_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  ack_phase_q, ack_phase_d;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign byte_in = {shreg_q[I2C_BYTE_W-2:0], sda_smp};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    txshreg_d   = txshreg_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    tx_req_d    = 1'b0;
    rx_valid_d  = 1'b0;
    rw_d        = rw_q;
    busy_d      = busy_q;
    ack_phase_d = ack_phase_q;

    if (!i2c_enable) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shreg_d   = byte_in;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            if (byte_in[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
              rw_d        = byte_in[0];
              busy_d      = 1'b1;
              tx_req_d    = byte_in[0];
              ack_phase_d = 1'b0;
              state_d     = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First fall pulls SDA for the ACK, second fall ends the ACK slot.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            if (rw_q) begin
              txshreg_d = tx_data;
              sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
              state_d   = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_d   = byte_in;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            rx_data_d   = byte_in;
            rx_valid_d  = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = WR_ACK;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            txshreg_d = {txshreg_q[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_d  = ~txshreg_q[I2C_BYTE_W-2];
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              ack_phase_d = 1'b0;
              state_d     = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            if (ack_phase_q) begin
              txshreg_d   = tx_data;
              sda_oe_d    = ~tx_data[I2C_BYTE_W-1];
              ack_phase_d = 1'b0;
              state_d     = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
          if (scl_rise) begin
            if (!sda_smp) begin
              tx_req_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i2c_reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shreg_q     <= '0;
      txshreg_q   <= '0;
      rx_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      tx_req_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      ack_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      txshreg_q   <= txshreg_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      tx_req_q    <= tx_req_d;
      rx_valid_q  <= rx_valid_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      ack_phase_q <= ack_phase_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign tx_req   = tx_req_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bus-level bench for i2c_slave with rx/read scoreboards
module tb_i2c_slave;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  bit oe_seen = 0;
  bit busy_seen = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_src[$];

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk         (clk),
    .i2c_reset_n (rst_n),
    .i2c_enable  (en),
    .scl_in      (scl_m),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rw          (rw),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check("rx_expected", exp_rx.size() != 0, 1);
      if (exp_rx.size() != 0) check("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_req) begin
      tx_cnt++;
      if (tx_src.size() != 0) tx_data = tx_src.pop_front();
      else tx_data = 8'hFF;
    end
    if (sda_oe) oe_seen = 1;
    if (busy) busy_seen = 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(4 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_in;   wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] addr_byte;
    int         rx0, tx0;

    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    wait_clk(4 * Q);

    // write 0xA5 to address 0x50
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    check("wr_rw", rw, 0);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, ack);
    check("wr_data_ack", ack, 0);
    i2c_stop();
    check("wr_busy_after_stop", busy, 0);
    check("wr_rx_count", rx_cnt - rx0, 1);

    // address mismatch
    rx0 = rx_cnt; tx0 = tx_cnt; oe_seen = 0; busy_seen = 0;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mm_addr_nack", ack, 1);
    write_byte(8'h11, ack);
    check("mm_data_nack", ack, 1);
    i2c_stop();
    check("mm_oe_seen", oe_seen, 0);
    check("mm_busy_seen", busy_seen, 0);
    check("mm_rx_count", rx_cnt - rx0, 0);
    check("mm_tx_count", tx_cnt - tx0, 0);

    // read 0x3C (ACK) then 0xC3 (NACK)
    tx0 = tx_cnt;
    tx_src.push_back(8'h3C); exp_rd.push_back(8'h3C);
    tx_src.push_back(8'hC3); exp_rd.push_back(8'hC3);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_rw", rw, 1);
    read_byte(d);
    check("rd_byte0", d, exp_rd.pop_front());
    write_bit(1'b0);
    read_byte(d);
    check("rd_byte1", d, exp_rd.pop_front());
    write_bit(1'b1);
    wait_clk(Q);
    check("rd_oe_after_nack", sda_oe, 0);
    check("rd_busy_after_nack", busy, 0);
    check("rd_tx_req_count", tx_cnt - tx0, 2);
    i2c_stop();

    // repeated START in the middle of a write data byte
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    check("rs_busy_cleared", busy, 0);
    tx_src.push_back(8'h5A); exp_rd.push_back(8'h5A);
    write_byte(8'hA1, ack);
    check("rs_read_ack", ack, 0);
    check("rs_rw", rw, 1);
    read_byte(d);
    check("rs_read_byte", d, exp_rd.pop_front());
    write_bit(1'b1);
    i2c_stop();
    check("rs_no_partial_rx", rx_cnt - rx0, 0);

    // reset pulse while the address ACK is being driven
    i2c_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
    sda_m = 1'b1;
    wait_clk(Q);
    check("rst_mid_ack_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ack_oe_at_edge", sda_oe, 0);
    check("rst_mid_ack_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("post_rst_addr_ack", ack, 0);
    exp_rx.push_back(8'h77);
    write_byte(8'h77, ack);
    check("post_rst_data_ack", ack, 0);
    i2c_stop();
    check("post_rst_rx_count", rx_cnt - rx0, 1);

    // disabled target ignores a valid frame
    en = 1'b0;
    rx0 = rx_cnt; oe_seen = 0;
    i2c_start();
    write_byte(8'hA0, ack);
    check("dis_addr_nack", ack, 1);
    write_byte(8'hA5, ack);
    check("dis_data_nack", ack, 1);
    i2c_stop();
    check("dis_oe_seen", oe_seen, 0);
    check("dis_rx_count", rx_cnt - rx0, 0);
    en = 1'b1;
    wait_clk(4 * Q);
    i2c_start();
    write_byte(8'hA0, ack);
    check("reen_addr_ack", ack, 0);
    exp_rx.push_back(8'h3E);
    write_byte(8'h3E, ack);
    check("reen_data_ack", ack, 0);
    i2c_stop();
    check("reen_rx_count", rx_cnt - rx0, 1);

    check("rx_queue_drained", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
